rx_serial_aligner: RTL and testbench
====================================

Name: rx_serial_aligner

Overview:
Receive-side serial-to-parallel stage that sits directly downstream of the PHY serializer. It takes the serial bit stream on the fast serial clock and finds the byte boundary using the COM symbol (0xBC). It declares the link active after a run of consecutive COMs, then presents recovered bytes to the receive unstriping logic. COM bytes seen after lock are treated as idle and marked not-valid.

Parameters:
COM, 8'hBC, alignment/idle symbol
COM_COUNT, 4, consecutive boundary-aligned COMs required to reach ACTIVE (range 2..15)

Ports:
clk  input  1  serial bit clock (the codebase's clk32 domain), rising edge
reset  input  1  synchronous, active-low; sampled on rising clk
data_in  input  1  serial bit, MSB of each byte first
data_out  output  8  recovered byte, held for 8 clk cycles
valid_out  output  1  data_out holds a non-COM byte; held with data_out
active  output  1  byte alignment achieved (state ACTIVE)

Behaviour:
- Reset (reset==0 at posedge):
  - state=SEARCH; shift reg sr=0, bit_cnt=0, com_cnt=0.
  - data_out=8'h00, valid_out=0, active=0.
  - Applies from any state, including mid-byte in ACTIVE; no partial byte is emitted.
- Every non-reset edge: sr <= {sr[6:0], data_in}.
- window = {sr[6:0], data_in}, combinational: the 8 most recent bits, newest in the LSB.
- bit_cnt is a 3-bit wrap counter; a byte boundary occurs when bit_cnt==7.
- SEARCH:
  - Compare window to COM every cycle (sliding).
  - On match: state=LOCKING, bit_cnt<=0, com_cnt<=1.
  - Otherwise stay in SEARCH; bit_cnt is don't-care but held at 0.
- LOCKING:
  - bit_cnt increments each cycle.
  - At a boundary where window==COM: com_cnt<=com_cnt+1. If com_cnt+1==COM_COUNT, state=ACTIVE.
  - At a boundary where window!=COM: state=SEARCH, com_cnt<=0. That same window is not re-checked for a sliding match; searching resumes next cycle.
  - data_out and valid_out stay at their reset values.
- ACTIVE:
  - active=1 (registered; rises on the edge that enters ACTIVE).
  - At each boundary: data_out<=window; valid_out<=(window!=COM).
  - Both outputs are held unchanged for the following 7 cycles.
  - The first data_out update happens at the first boundary after entering ACTIVE, i.e. 8 cycles later. The final locking COM is never output.
  - ACTIVE is left only by reset; there is no loss-of-lock detection in this block.
- Latency: the last bit of a byte is sampled at edge t; data_out is visible after edge t (same edge).
- Width rules: com_cnt is 4 bits and saturates conceptually at COM_COUNT, since the state changes there.
- Simultaneous events: reset has priority over all state updates.

Test Plan:
- Reset hold: reset=0 for 4 cycles with random data_in -> data_out=00, valid_out=0, active=0, state SEARCH throughout.
- Offset lock: 3 random bits, then 4×0xBC MSB-first, then 0xFF, 0xF4, 0xBC, 0xE8.
  - First match at edge k; active rises at edge k+24.
  - data_out=FF with valid_out=1 at k+32; data_out=F4 at k+40.
  - data_out=BC with valid_out=0 at k+48; data_out=E8 with valid_out=1 at k+56.
- Broken lock: 2×0xBC then 0x3C -> returns to SEARCH at the 0x3C boundary, active stays 0. Then 4×0xBC -> active=1.
- No COM: 200 cycles of 0x55 pattern, or all-ones -> active=0, valid_out=0 throughout.
- Reset mid-operation: in ACTIVE, assert reset=0 at bit 4 of a data byte -> next edge active=0, data_out=00, valid_out=0. After release, 4 fresh COMs are required before active rises again.
- Parameter: COM_COUNT=2 -> active rises 8 cycles after the first match.

Source files
------------

// File: rtl/rx_serial_aligner.sv
// Serial-to-parallel receive aligner: finds the byte boundary from a run of
// COM symbols, then emits recovered bytes with COM idles marked not-valid.
module rx_serial_aligner #(
    parameter logic [7:0] COM       = 8'hBC,
    parameter int         COM_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t      state, state_n;
    // Only the seven older bits are stored; the eighth is data_in itself.
    logic [6:0]  sr, sr_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [3:0]  com_cnt, com_cnt_n;
    logic [7:0]  data_out_n;
    logic        valid_n;
    logic [7:0]  window;
    logic        boundary;

    assign window   = {sr, data_in};
    assign boundary = (bit_cnt == 3'd7);
    assign active   = (state == ACTIVE);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        state_n    = state;
        sr_n       = window[6:0];
        bit_cnt_n  = bit_cnt + 3'd1;
        com_cnt_n  = com_cnt;
        data_out_n = data_out;
        valid_n    = valid_out;

        case (state)
            SEARCH: begin
                bit_cnt_n = 3'd0;
                if (window == COM) begin
                    state_n   = LOCKING;
                    com_cnt_n = 4'd1;
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (window == COM) begin
                        com_cnt_n = com_cnt + 4'd1;
                        if (com_cnt_n == 4'(COM_COUNT))
                            state_n = ACTIVE;
                    end else begin
                        // A broken run falls back without re-testing this window.
                        state_n   = SEARCH;
                        com_cnt_n = 4'd0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    data_out_n = window;
                    valid_n    = (window != COM);
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!reset) begin
            state     <= SEARCH;
            sr        <= 7'd0;
            bit_cnt   <= 3'd0;
            com_cnt   <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            bit_cnt   <= bit_cnt_n;
            com_cnt   <= com_cnt_n;
            data_out  <= data_out_n;
            valid_out <= valid_n;
        end
    end

endmodule

// File: tb/tb_rx_serial_aligner.sv
// Randomized and directed bench for rx_serial_aligner, checking two lock
// depths (4 and 2 COMs) against a bit-history reference model.
module tb_rx_serial_aligner;

    localparam logic [7:0] COM = 8'hBC;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out4, data_out2;
    logic       valid_out4, valid_out2;
    logic       active4, active2;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 -> COM_COUNT=4, index 1 -> COM_COUNT=2
    int        need   [2] = '{4, 2};
    int        mode   [2];   // 0 searching, 1 counting COMs, 2 aligned
    int        anchor [2];   // edge index of the first sliding match
    int        runs   [2];
    logic [7:0] m_out [2];
    logic       m_val [2];
    bit         hist[$];
    int         edge_idx;

    rx_serial_aligner #(.COM(COM), .COM_COUNT(4)) u_dut4 (
        .clk(clk), .reset(reset), .data_in(data_in),
        .data_out(data_out4), .valid_out(valid_out4), .active(active4)
    );

    rx_serial_aligner #(.COM(COM), .COM_COUNT(2)) u_dut2 (
        .clk(clk), .reset(reset), .data_in(data_in),
        .data_out(data_out2), .valid_out(valid_out2), .active(active2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%02h expected=%02h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(1'b0);
        edge_idx = 0;
        for (int j = 0; j < 2; j++) begin
            mode[j] = 0; anchor[j] = 0; runs[j] = 0;
            m_out[j] = 8'h00; m_val[j] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit b);
        logic [7:0] win;
        hist.push_back(b);
        void'(hist.pop_front());
        win = 8'h00;
        for (int i = 0; i < 8; i++) win = 8'(win * 2 + hist[i]);
        for (int j = 0; j < 2; j++) begin
            case (mode[j])
                0: if (win == COM) begin
                    mode[j] = 1; anchor[j] = edge_idx; runs[j] = 1;
                end
                1: if ((edge_idx - anchor[j]) % 8 == 0) begin
                    if (win == COM) begin
                        runs[j]++;
                        if (runs[j] == need[j]) mode[j] = 2;
                    end else begin
                        mode[j] = 0;
                    end
                end
                default: if ((edge_idx - anchor[j]) % 8 == 0) begin
                    m_out[j] = win;
                    m_val[j] = (win != COM);
                end
            endcase
        end
        edge_idx++;
    endtask

    task automatic step(input bit b, input bit rst);
        @(negedge clk);
        data_in = b;
        reset   = rst;
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge(b);
        #1;
        check("data4",   data_out4,        m_out[0]);
        check("valid4",  8'(valid_out4),   8'(m_val[0]));
        check("active4", 8'(active4),      8'(mode[0] == 2));
        check("data2",   data_out2,        m_out[1]);
        check("valid2",  8'(valid_out2),   8'(m_val[1]));
        check("active2", 8'(active2),      8'(mode[1] == 2));
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        model_reset();

        // Reset hold with random serial data
        do_reset(4);
        check("rst_data", data_out4, 8'h00);
        check("rst_active", 8'(active4), 8'h00);

        // Offset lock: three stray bits, four COMs, then data and an idle
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 4; i++) send_byte(COM);
        check("lock_active", 8'(active4), 8'h01);
        send_byte(8'hFF);
        check("lock_ff", data_out4, 8'hFF);
        send_byte(8'hF4);
        check("lock_f4", data_out4, 8'hF4);
        send_byte(COM);
        check("lock_idle", 8'(valid_out4), 8'h00);
        send_byte(8'hE8);
        check("lock_e8", data_out4, 8'hE8);
        check("lock_e8_valid", 8'(valid_out4), 8'h01);

        // Broken lock, then a clean run
        do_reset(2);
        send_byte(COM); send_byte(COM); send_byte(8'h3C);
        check("broken_active", 8'(active4), 8'h00);
        for (int i = 0; i < 4; i++) send_byte(COM);
        check("relock_active", 8'(active4), 8'h01);

        // No COM in the stream: alternating bits, then all ones
        do_reset(2);
        for (int i = 0; i < 200; i++) step(1'(i % 2), 1'b1);
        check("noc55_active", 8'(active4), 8'h00);
        for (int i = 0; i < 200; i++) step(1'b1, 1'b1);
        check("noc_ones_valid", 8'(valid_out4), 8'h00);

        // Reset in the middle of a data byte while aligned
        for (int i = 0; i < 4; i++) send_byte(COM);
        send_byte(8'h5A);
        for (int i = 7; i >= 4; i--) step(1'(8'hC3 >> i), 1'b1);
        step(1'b1, 1'b0);
        check("midrst_active", 8'(active4), 8'h00);
        check("midrst_data", data_out4, 8'h00);
        for (int i = 0; i < 3; i++) send_byte(COM);
        check("midrst_3com", 8'(active4), 8'h00);
        send_byte(COM);
        check("midrst_4com", 8'(active4), 8'h01);

        // Random byte stream rich in COMs, with bit slips and occasional resets
        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 2)       do_reset($urandom_range(1, 3));
            else if (r < 8)  for (int i = 0; i < $urandom_range(1, 7); i++)
                                 step(1'($urandom_range(0, 1)), 1'b1);
            else if (r < 55) send_byte(COM);
            else             send_byte(8'($urandom()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
